// File: rtl/result_tx_pkg.sv
// -----------------------------------------------------------------------------
// result_tx_pkg
// Shared types and constants for the result transmitter.
//   state_t          : transmitter FSM states
//   ASCII_*          : byte constants used when building the output frame
//   nibble_to_ascii  : 4-bit value to upper-case hex ASCII character
// -----------------------------------------------------------------------------
package result_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // Digits 0-9 start at '0'; 10-15 are offset from 'A' so only upper case is produced.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    logic [7:0] wide;
    wide = {4'b0000, nibble};
    if (nibble < 4'd10) begin
      return ASCII_0 + wide;
    end
    return ASCII_A + (wide - 8'd10);
  endfunction

endpackage

// File: rtl/hex_ascii.sv
// -----------------------------------------------------------------------------
// hex_ascii
// Combinational converter from one hex nibble to its upper-case ASCII code.
// Ports:
//   nibble : input  [3:0] value 0-15
//   ascii  : output [7:0] '0'-'9' or 'A'-'F'
// -----------------------------------------------------------------------------
module hex_ascii
  import result_tx_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = nibble_to_ascii(nibble);
  end

endmodule

// File: rtl/result_tx.sv
// -----------------------------------------------------------------------------
// result_tx
// Sends a latched binary value as upper-case hex ASCII, most significant digit
// first, optionally followed by CR LF, one byte per txclk strobe.
// Parameters:
//   DIGITS    : number of hex digits; value is 4*DIGITS bits wide
//   SEND_CRLF : 1 appends 0x0D 0x0A after the digits
// Ports:
//   hz100   : input      clock, rising edge
//   reset   : input      synchronous active-high reset
//   start   : input      send request, honoured only while idle
//   value   : input      value to send, captured on an accepted start
//   txready : input      sink can take a byte
//   txdata  : output [7:0] current byte (registered)
//   txclk   : output     one-cycle strobe, sink takes txdata while high (registered)
//   busy    : output     high while a frame is in progress
//   done    : output     one-cycle pulse after the final byte
// -----------------------------------------------------------------------------
module result_tx
  import result_tx_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SEND_CRLF = 1
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  txready,
  output logic [7:0]            txdata,
  output logic                  txclk,
  output logic                  busy,
  output logic                  done
);

  localparam int N     = DIGITS + 2 * SEND_CRLF;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int VW    = 4 * DIGITS;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [VW-1:0]    latched;

  logic             last_byte;
  int               sel_k;
  logic [VW-1:0]    src;
  logic [3:0]       nibble;
  logic [7:0]       digit_ascii;
  logic [7:0]       next_byte;

  assign last_byte = (idx == IDX_W'(N - 1));

  // The byte to load next is byte 0 of the incoming value when idle, otherwise
  // the byte after the current index taken from the latched copy.
  always_comb begin
    sel_k  = 0;
    src    = latched;
    nibble = 4'h0;
    if (state == IDLE) begin
      sel_k = 0;
      src   = value;
    end else begin
      sel_k = int'(idx) + 1;
      src   = latched;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (i == sel_k) begin
        nibble = src[4*(DIGITS-1-i) +: 4];
      end
    end
  end

  hex_ascii u_hex_ascii (
    .nibble (nibble),
    .ascii  (digit_ascii)
  );

  // Bytes past the digits are the line terminator, CR first.
  always_comb begin
    next_byte = digit_ascii;
    if (sel_k >= DIGITS) begin
      next_byte = (sel_k == DIGITS) ? ASCII_CR : ASCII_LF;
    end
  end

  // State register.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. txready is only looked at while a byte is waiting in SEND.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (txready) state_next = GAP;
      GAP:     state_next = last_byte ? DONE : SEND;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: latched value, byte index, outgoing byte and strobe.
  // txclk is set on the same edge the FSM enters GAP, so it is high exactly
  // for the GAP cycle and can never be high twice in a row.
  always_ff @(posedge hz100) begin
    if (reset) begin
      txdata  <= 8'h00;
      txclk   <= 1'b0;
      idx     <= '0;
      latched <= '0;
    end else begin
      txclk <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            latched <= value;
            txdata  <= next_byte;
            idx     <= '0;
          end
        end
        SEND: begin
          if (txready) begin
            txclk <= 1'b1;
          end
        end
        GAP: begin
          if (!last_byte) begin
            idx    <= idx + IDX_W'(1);
            txdata <= next_byte;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      SEND, GAP: busy = 1'b1;
      DONE:      done = 1'b1;
      default: begin
      end
    endcase
  end

endmodule
